// File: rtl/add16_pkg.sv
// add16_pkg: shared state encoding and default geometry for the nibble-serial adder
package add16_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int NIB_W_DEF   = 4;
    localparam int NUM_NIB_DEF = 4;
    localparam int W_DEF       = NIB_W_DEF * NUM_NIB_DEF;
    localparam int IDX_W_DEF   = (NUM_NIB_DEF > 1) ? $clog2(NUM_NIB_DEF) : 1;
endpackage

// File: rtl/add16_nibble_seq_slice.sv
// nibble_adder: combinational N-bit adder slice shared by the serial controller
module nibble_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
endmodule

// File: rtl/add16_nibble_seq.sv
// add16_nibble_seq: nibble-serial 16-bit adder with valid/ready in and out; ADD16_SUB_EN adds the op (subtract) port
module add16_nibble_seq
    import add16_pkg::*;
#(
    parameter int NIB_W   = NIB_W_DEF,
    parameter int NUM_NIB = NUM_NIB_DEF,
    localparam int W      = NIB_W * NUM_NIB,
    localparam int IDX_W  = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef ADD16_SUB_EN
    input  logic         op,
`endif
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);
    state_t             state, state_nx;
    logic [W-1:0]       ra, rb, sum_r;
    logic [IDX_W-1:0]   idx;
    logic               carry, cout_r;
    logic [NIB_W-1:0]   ns;
    logic               nc;
    logic [W-1:0]       b_in;
    logic               c_in;
    logic               last;
    logic               accept;
`ifdef ADD16_SUB_EN
    assign b_in = op ? ~b : b;
    assign c_in = op | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif
    assign last   = idx == IDX_W'(NUM_NIB - 1);
    assign accept = start_valid && state == IDLE;
    nibble_adder #(.N(NIB_W)) u_slice (
        .x  (ra[idx*NIB_W +: NIB_W]),
        .y  (rb[idx*NIB_W +: NIB_W]),
        .ci (carry),
        .s  (ns),
        .co (nc)
    );
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_valid ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = res_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // operand capture on accept, then one nibble per cycle through the shared slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra     <= '0;
            rb     <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            ra     <= a;
            rb     <= b_in;
            carry  <= c_in;
            sum_r  <= '0;
            cout_r <= 1'b0;
            idx    <= '0;
        end else if (state == RUN) begin
            sum_r[idx*NIB_W +: NIB_W] <= ns;
            carry  <= nc;
            idx    <= last ? idx : idx + 1'b1;
            if (last) cout_r <= nc;
        end
    end
    assign start_ready = state == IDLE;
    assign res_valid   = state == DONE;
    assign busy        = state != IDLE;
    assign sum         = sum_r;
    assign cout        = cout_r;
endmodule

// File: tb/tb_add16_nibble_seq.sv
// tb_add16_nibble_seq: scoreboard bench for the nibble-serial adder
module tb_add16_nibble_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        op = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
    int          vectors = 0;
    int          miscompares = 0;
    logic [16:0] sb [$];

    add16_nibble_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
`ifdef ADD16_SUB_EN
        .op          (op),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic to, input int hold);
        int          lat;
        logic [16:0] exp;
        logic [15:0] s0;
        logic        c0;
        @(negedge clk);
        check("start_ready_idle", start_ready, 1);
        a = ta; b = tb_; cin = tc; op = to; start_valid = 1'b1;
        exp = to ? ({1'b0, ta} + {1'b0, ~tb_} + 17'd1) : ({1'b0, ta} + {1'b0, tb_} + {16'd0, tc});
        sb.push_back(exp);
        @(negedge clk);
        start_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); op = 1'($urandom);
        check("busy_run", busy, 1);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 4);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            exp = sb.pop_front();
            check("sum", sum, exp[15:0]);
            check("cout", cout, exp[16]);
        end
        s0 = sum; c0 = cout;
        if (hold > 0) start_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_sum", sum, s0);
            check("hold_cout", cout, c0);
            check("hold_start_ready", start_ready, 0);
            check("hold_res_valid", res_valid, 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_res_valid", res_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_start_ready", start_ready, 1);
        start_valid = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_start_ready", start_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0000, 16'h000A, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h1234, 16'h0FFF, 1'b1, 1'b0, 0);
        do_op(16'hABCD, 16'h5432, 1'b1, 1'b0, 3);
`ifdef ADD16_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
`endif
        for (int i = 0; i < 6; i++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 0);
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; op = 1'b0; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_start_ready", start_ready, 1);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
